// File: rtl/mem_bus_pkg.sv
// Shared definitions for the sram-like bus bridges: FSM state encoding and
// bus transfer size codes.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/dmem_sram_bridge_wen2size.sv
// Byte write mask to bus transfer size; shared with the instruction-side bridge.
module wen2size
    import mem_bus_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size
);

    always_comb begin
        size = SZ_WORD;
        case (wen)
            4'b1111:                            size = SZ_WORD;
            4'b0011, 4'b1100:                   size = SZ_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
            // Masks the CPU never produces fall back to a word transfer.
            default:                            size = SZ_WORD;
        endcase
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Converts the CPU's single-cycle data SRAM port into a split-transaction
// sram-like bus, stalling the pipeline while a transaction is outstanding.
module dmem_sram_bridge
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_rsize,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              other_stall,
    output logic              data_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t            state;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_wr;
    logic [1:0]        req_size;
    logic [1:0]        wsize;

    wen2size u_wen2size (
        .wen  (cpu_wen),
        .size (wsize)
    );

    assign req_wr   = |cpu_wen;
    assign req_size = req_wr ? wsize : cpu_rsize;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cpu_rdata <= '0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_en) begin
                        wr_q    <= req_wr;
                        size_q  <= req_size;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        state   <= bus_addr_ok ? WAIT : ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) state <= WAIT;
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        if (!wr_q) cpu_rdata <= bus_rdata;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Leave only when the whole pipeline advances, so a held
                    // M-stage request is not issued a second time.
                    if (!other_stall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_req    = 1'b0;
        data_stall = 1'b0;
        bus_wr     = wr_q;
        bus_size   = size_q;
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        case (state)
            IDLE: begin
                bus_req    = cpu_en;
                data_stall = cpu_en;
                bus_wr     = cpu_en ? req_wr    : 1'b0;
                bus_size   = cpu_en ? req_size  : 2'd0;
                bus_addr   = cpu_en ? cpu_addr  : '0;
                bus_wdata  = cpu_en ? cpu_wdata : '0;
            end
            ADDR: begin
                bus_req    = 1'b1;
                data_stall = 1'b1;
            end
            WAIT: begin
                data_stall = 1'b1;
            end
            DONE: begin
                data_stall = 1'b0;
            end
            default: begin
                data_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: expected bus requests are queued by the
// stimulus and checked by an independent bus monitor.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_rsize;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        other_stall;
    logic        data_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en),
        .cpu_wen     (cpu_wen),
        .cpu_rsize   (cpu_rsize),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .other_stall (other_stall),
        .data_stall  (data_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t req_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_hs    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bus monitor: every cycle with bus_req must match the oldest queued request.
    always @(negedge clk) begin
        if (bus_req === 1'b1) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 32'(bus_req), 32'd0);
            end else begin
                chk("bus_wr",    32'(bus_wr),   32'(req_q[0].wr));
                chk("bus_size",  32'(bus_size), 32'(req_q[0].size));
                chk("bus_addr",  bus_addr,      req_q[0].addr);
                chk("bus_wdata", bus_wdata,     req_q[0].wdata);
                if (bus_addr_ok) begin
                    void'(req_q.pop_front());
                    n_hs++;
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            cpu_en = 1'b0; cpu_wen = 4'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
            @(negedge clk);
            chk("idle_stall", 32'(data_stall), 32'd0);
            chk("idle_req",   32'(bus_req),    32'd0);
            @(posedge clk);
        end
    endtask

    // One complete access; called just after a rising edge, returns just after
    // the DONE->IDLE edge with cpu_en still asserted.
    task automatic access(input logic [3:0] wen, input logic [1:0] rsize,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_wr, input logic [1:0] exp_size,
                          input int ad, input int dd, input logic [31:0] rd,
                          input logic [31:0] exp_rd, input int hold, input logic spur);
        int stall_cycles = 0;
        req_t r;
        r.wr = exp_wr; r.size = exp_size; r.addr = addr; r.wdata = wdata;
        req_q.push_back(r);
        for (int i = 0; i <= ad; i++) begin
            #1;
            cpu_en = 1'b1; cpu_wen = wen; cpu_rsize = rsize;
            cpu_addr = addr; cpu_wdata = wdata; other_stall = 1'b0;
            bus_addr_ok = (i == ad);
            bus_data_ok = spur;
            bus_rdata   = 32'hBAD0_BAD0;
            @(negedge clk);
            chk("req_held", 32'(bus_req), 32'd1);
            if (data_stall) stall_cycles++;
            @(posedge clk);
        end
        for (int j = 0; j <= dd; j++) begin
            #1;
            bus_addr_ok = 1'b0;
            bus_data_ok = (j == dd);
            bus_rdata   = (j == dd) ? rd : 32'h5555_AAAA;
            @(negedge clk);
            chk("req_dropped", 32'(bus_req), 32'd0);
            if (data_stall) stall_cycles++;
            @(posedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            #1;
            bus_data_ok = 1'b0;
            other_stall = (h < hold);
            @(negedge clk);
            chk("done_stall", 32'(data_stall), 32'd0);
            chk("done_rdata", cpu_rdata, exp_rd);
            @(posedge clk);
        end
        #1 other_stall = 1'b0;
        chk("stall_cycles", 32'(stall_cycles), 32'(ad + dd + 2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        rst = 1'b0; cpu_en = 1'b0; cpu_wen = 4'b0; cpu_rsize = 2'd0;
        cpu_addr = '0; cpu_wdata = '0; other_stall = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", cpu_rdata,         32'd0);
        chk("rst_stall", 32'(data_stall),   32'd0);
        chk("rst_req",   32'(bus_req),      32'd0);
        chk("rst_wr",    32'(bus_wr),       32'd0);
        chk("rst_size",  32'(bus_size),     32'd0);
        chk("rst_addr",  bus_addr,          32'd0);
        chk("rst_wdata", bus_wdata,         32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);

        // Word read, zero wait
        access(4'b0000, 2'd2, 32'h0000_1000, 32'h0, 1'b0, 2'd2, 0, 0,
               32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
        idle(1);
        // Byte write, addr_ok delayed 3 cycles; rdata untouched
        access(4'b0100, 2'd0, 32'h0000_1002, 32'h00AB_0000, 1'b1, 2'd0, 3, 0,
               32'h1111_1111, 32'hDEAD_BEEF, 0, 1'b0);
        idle(1);
        // Half read held in DONE by other_stall for 2 cycles
        access(4'b0000, 2'd1, 32'h0000_2002, 32'h0, 1'b0, 2'd1, 1, 1,
               32'h0000_CAFE, 32'h0000_CAFE, 2, 1'b0);
        idle(1);
        // Byte write with slow data_ok, then an irregular mask (word size)
        access(4'b0001, 2'd0, 32'h0000_2100, 32'h0000_0077, 1'b1, 2'd0, 0, 2,
               32'h2222_2222, 32'h0000_CAFE, 0, 1'b0);
        access(4'b0110, 2'd0, 32'h0000_2104, 32'h0012_3400, 1'b1, 2'd2, 1, 0,
               32'h3333_3333, 32'h0000_CAFE, 0, 1'b0);
        idle(1);

        // Spurious data_ok in IDLE
        #1 bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_0000;
        @(posedge clk);
        #1 bus_data_ok = 1'b0;
        @(negedge clk);
        chk("spur_idle_rdata", cpu_rdata, 32'h0000_CAFE);
        chk("spur_idle_stall", 32'(data_stall), 32'd0);
        @(posedge clk);
        // data_ok alongside addr_ok handshaking must not complete the read
        access(4'b0000, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 2'd2, 2, 0,
               32'h1357_2468, 32'h1357_2468, 0, 1'b1);
        idle(1);

        // Reset while in WAIT
        req_q.push_back('{1'b0, 2'd2, 32'h0000_5000, 32'h0});
        #1 cpu_en = 1'b1; cpu_wen = 4'b0; cpu_rsize = 2'd2;
        cpu_addr = 32'h0000_5000; cpu_wdata = 32'h0; bus_addr_ok = 1'b1;
        @(posedge clk);
        #1 bus_addr_ok = 1'b0; cpu_en = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("wait_stall", 32'(data_stall), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdata", cpu_rdata,       32'd0);
        chk("mid_rst_req",   32'(bus_req),    32'd0);
        chk("mid_rst_stall", 32'(data_stall), 32'd0);
        @(posedge clk);
        #1 bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 bus_data_ok = 1'b0;
        @(negedge clk);
        chk("late_data_ok_rdata", cpu_rdata,       32'd0);
        chk("late_data_ok_stall", 32'(data_stall), 32'd0);
        @(posedge clk);

        // Half write then word read, back to back
        hs0 = n_hs;
        access(4'b1100, 2'd0, 32'h0000_4002, 32'hBEEF_0000, 1'b1, 2'd1, 0, 0,
               32'h4444_4444, 32'h0, 0, 1'b0);
        access(4'b0000, 2'd2, 32'h0000_4000, 32'h0, 1'b0, 2'd2, 0, 0,
               32'hBEEF_1234, 32'hBEEF_1234, 0, 1'b0);
        idle(2);
        chk("b2b_requests", 32'(n_hs - hs0), 32'd2);
        chk("queue_drained", 32'(req_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
